// File: rtl/acs_unit.sv
// acs_unit: add-compare-select cell for one trellis state of a Viterbi decoder.
// Adds the Hamming branch metric to each predecessor's path metric, keeps the
// smaller sum as the survivor, optionally normalizes, saturates, and registers
// the survivor metric and decision with one cycle of latency.
//
// Input handshake: there is no ready signal. A cycle is an accepted update
// when the block is in RUN, in_valid is 1 and start is 0; only then are the
// metric inputs sampled. out_valid pulses for exactly one cycle after each
// accepted update and is 0 otherwise, while pm_out/decision hold.
module acs_unit #(
    parameter int PM_W    = 8,
    parameter int INIT_PM = 0,
    parameter int STEP_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [1:0]        path_0_bmc,
    input  logic [1:0]        path_1_bmc,
    input  logic [PM_W-1:0]   pm_in0,
    input  logic [PM_W-1:0]   pm_in1,
    input  logic              norm_in,
    output logic [PM_W-1:0]   pm_out,
    output logic              decision,
    output logic              out_valid,
    output logic              norm_req,
    output logic [STEP_W-1:0] step_cnt,
    output logic              dbg_state_o
);

    // Candidates carry one extra bit so the add never wraps.
    localparam int CW = PM_W + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Amount removed by a global normalize: half of the metric range.
    localparam logic [CW-1:0]   NORM_OFF = {2'b01, {(PM_W-1){1'b0}}};
    // Largest value pm_out can represent.
    localparam logic [CW-1:0]   PM_MAX   = {1'b0, {PM_W{1'b1}}};
    localparam logic [PM_W-1:0] INIT_VAL = PM_W'(INIT_PM);

    logic [0:0]        state_q, state_d;
    logic [PM_W-1:0]   pm_q, pm_d;
    logic              dec_q, dec_d;
    logic              valid_q, valid_d;
    logic              nreq_q, nreq_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;

    logic [CW-1:0]     cand0;
    logic [CW-1:0]     cand1;
    logic              take1;
    logic [CW-1:0]     sel;
    logic [CW-1:0]     normed;
    logic [PM_W-1:0]   result;
    logic              accept;

    // Start wins over a coincident in_valid; that update is dropped.
    assign accept = (state_q == S_RUN) && in_valid && !start;

    // Add-compare-select datapath with normalize (floored at 0) then saturation.
    always_comb begin
        cand0  = {1'b0, pm_in0} + {{(CW-2){1'b0}}, path_0_bmc};
        cand1  = {1'b0, pm_in1} + {{(CW-2){1'b0}}, path_1_bmc};
        // Strict compare: a tie keeps predecessor 0.
        take1  = (cand1 < cand0);
        sel    = take1 ? cand1 : cand0;
        normed = sel;
        if (norm_in) begin
            normed = (sel >= NORM_OFF) ? (sel - NORM_OFF) : '0;
        end
        result = (normed > PM_MAX) ? {PM_W{1'b1}} : normed[PM_W-1:0];
    end

    // Next-state logic for the FSM, metric registers and step counter.
    always_comb begin
        state_d = state_q;
        pm_d    = pm_q;
        dec_d   = dec_q;
        valid_d = 1'b0;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = S_RUN;
            pm_d    = INIT_VAL;
            dec_d   = 1'b0;
            cnt_d   = '0;
        end else if (accept) begin
            pm_d    = result;
            dec_d   = take1;
            valid_d = 1'b1;
            cnt_d   = cnt_q + STEP_W'(1);
        end
        // The request flag tracks the MSB of whatever metric is being stored.
        nreq_d = pm_d[PM_W-1];
    end

    // State registers with asynchronous active-low reset back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pm_q    <= '0;
            dec_q   <= 1'b0;
            valid_q <= 1'b0;
            nreq_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pm_q    <= pm_d;
            dec_q   <= dec_d;
            valid_q <= valid_d;
            nreq_q  <= nreq_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pm_out      = pm_q;
    assign decision    = dec_q;
    assign out_valid   = valid_q;
    assign norm_req    = nreq_q;
    assign step_cnt    = cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_acs_unit.sv
// Bench for acs_unit: directed vectors with literal expectations plus a
// behavioural integer model compared against the DUT on every falling edge.
module tb_acs_unit;

    localparam int PM_W    = 8;
    localparam int STEP_W  = 10;
    localparam int INIT_PM = 0;
    localparam int HALF    = 2 ** (PM_W - 1);
    localparam int MAXV    = 2 ** PM_W - 1;
    localparam int NSTEP   = 2 ** STEP_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [1:0]        path_0_bmc = '0;
    logic [1:0]        path_1_bmc = '0;
    logic [PM_W-1:0]   pm_in0 = '0;
    logic [PM_W-1:0]   pm_in1 = '0;
    logic              norm_in = 1'b0;
    logic [PM_W-1:0]   pm_out;
    logic              decision;
    logic              out_valid;
    logic              norm_req;
    logic [STEP_W-1:0] step_cnt;
    logic              dbg_state;

    acs_unit #(.PM_W(PM_W), .INIT_PM(INIT_PM), .STEP_W(STEP_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .path_0_bmc (path_0_bmc),
        .path_1_bmc (path_1_bmc),
        .pm_in0     (pm_in0),
        .pm_in1     (pm_in1),
        .norm_in    (norm_in),
        .pm_out     (pm_out),
        .decision   (decision),
        .out_valid  (out_valid),
        .norm_req   (norm_req),
        .step_cnt   (step_cnt),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_pm = 0;
    int m_dec = 0;
    int m_valid = 0;
    int m_cnt = 0;
    bit m_run = 1'b0;
    int c0, c1, s;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pm = 0; m_dec = 0; m_valid = 0; m_cnt = 0; m_run = 1'b0;
        end else if (start) begin
            m_pm = INIT_PM; m_dec = 0; m_valid = 0; m_cnt = 0; m_run = 1'b1;
        end else if (m_run && in_valid) begin
            c0 = int'(pm_in0) + int'(path_0_bmc);
            c1 = int'(pm_in1) + int'(path_1_bmc);
            if (c1 < c0) begin s = c1; m_dec = 1; end
            else         begin s = c0; m_dec = 0; end
            if (norm_in) s = (s > HALF) ? s - HALF : 0;
            if (s > MAXV) s = MAXV;
            m_pm    = s;
            m_valid = 1;
            m_cnt   = (m_cnt + 1) % NSTEP;
        end else begin
            m_valid = 0;
        end
    end

    // Compare process: outputs are stable around the falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("model_pm_out",    pm_out,    m_pm);
            check("model_decision",  decision,  m_dec);
            check("model_out_valid", out_valid, m_valid);
            check("model_norm_req",  norm_req,  (m_pm >= HALF) ? 1 : 0);
            check("model_step_cnt",  step_cnt,  m_cnt);
        end
    end

    // ---------------- driver ----------------
    task automatic step(input bit st, input bit v, input int p0, input int b0,
                        input int p1, input int b1, input bit nm);
        start      = st;
        in_valid   = v;
        pm_in0     = PM_W'(p0);
        path_0_bmc = 2'(b0);
        pm_in1     = PM_W'(p1);
        path_1_bmc = 2'(b1);
        norm_in    = nm;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;
        check("rst_pm_out",    pm_out,    0);
        check("rst_out_valid", out_valid, 0);
        check("rst_step_cnt",  step_cnt,  0);
        check("rst_norm_req",  norm_req,  0);
        rst_n = 1'b1;

        // IDLE ignores in_valid
        step(0, 1, 10, 2, 9, 1, 0);
        check("idle_out_valid", out_valid, 0);
        check("idle_step_cnt",  step_cnt,  0);

        // start loads INIT_PM
        step(1, 0, 0, 0, 0, 0, 0);
        check("start_pm_out",   pm_out,   0);
        check("start_step_cnt", step_cnt, 0);

        // basic update: 12 vs 10 -> pred 1
        step(0, 1, 10, 2, 9, 1, 0);
        check("basic_pm_out",    pm_out,    10);
        check("basic_decision",  decision,  1);
        check("basic_out_valid", out_valid, 1);
        check("basic_step_cnt",  step_cnt,  1);

        // no accepted update: outputs hold, garbage inputs ignored
        step(0, 0, 100, 0, 3, 0, 1);
        check("hold_out_valid", out_valid, 0);
        check("hold_pm_out",    pm_out,    10);
        check("hold_decision",  decision,  1);

        // tie 6 vs 6 -> pred 0
        step(0, 1, 5, 1, 4, 2, 0);
        check("tie_pm_out",   pm_out,   6);
        check("tie_decision", decision, 0);

        // 256 vs 257 -> saturate
        step(0, 1, 254, 2, 255, 2, 0);
        check("sat_pm_out",   pm_out,   255);
        check("sat_decision", decision, 0);
        check("sat_norm_req", norm_req, 1);

        // normalize 200 -> 72
        step(0, 1, 200, 0, 210, 1, 1);
        check("norm_pm_out",   pm_out,   72);
        check("norm_norm_req", norm_req, 0);
        step(0, 1, 200, 0, 210, 1, 0);
        check("nonorm_pm_out",   pm_out,   200);
        check("nonorm_norm_req", norm_req, 1);

        // normalize floored at 0
        step(0, 1, 50, 0, 100, 0, 1);
        check("floor_pm_out", pm_out, 0);

        // 257 normalized -> 129, no saturation
        step(0, 1, 255, 2, 255, 2, 1);
        check("ovf_norm_pm_out", pm_out, 129);

        // pred 1 with normalize: 150 -> 22
        step(0, 1, 180, 2, 150, 0, 1);
        check("norm_dec_pm_out",   pm_out,   22);
        check("norm_dec_decision", decision, 1);

        // mixed vectors, checked by the model
        for (int i = 0; i < 40; i++) begin
            step(0, ($urandom_range(0, 3) != 0), $urandom_range(0, MAXV), $urandom_range(0, 2),
                 $urandom_range(0, MAXV), $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
        end

        // asynchronous reset mid-frame
        step(0, 1, 30, 1, 40, 0, 0);
        check("pre_rst_pm_out", pm_out, 31);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pm_out",    pm_out,    0);
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_step_cnt",  step_cnt,  0);
        check("async_rst_decision",  decision,  0);
        check("async_rst_norm_req",  norm_req,  0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 20 + i, 1, 7, 2, 0);
            check("post_rst_out_valid", out_valid, 0);
        end

        // start has priority over in_valid
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 60, 0, 70, 0, 0);
        check("prio_pre_pm_out", pm_out, 60);
        step(1, 1, 5, 0, 5, 0, 0);
        check("prio_pm_out",    pm_out,    0);
        check("prio_out_valid", out_valid, 0);
        check("prio_step_cnt",  step_cnt,  0);

        // counter wrap
        for (int i = 0; i < NSTEP - 1; i++) begin
            step(0, 1, i % 200, i % 3, (i * 7) % 250, (i + 1) % 3, (i % 5) == 0);
        end
        check("wrap_pre_step_cnt", step_cnt, NSTEP - 1);
        step(0, 1, 1, 0, 2, 0, 0);
        check("wrap_step_cnt",  step_cnt,  0);
        check("wrap_out_valid", out_valid, 1);
        check("wrap_pm_out",    pm_out,    1);

        step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/acs_unit.md
ACS_UNIT -- requirements
Module: acs_unit

Interface
REQ-001 Parameter PM_W, default 8: path-metric width in bits, legal range 4..16.
REQ-002 Parameter INIT_PM, default 0: metric loaded on start; 0 for trellis state 0, 2^(PM_W-2) for all other states.
REQ-003 Parameter STEP_W, default 10: width of the trellis-step counter.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  frame start pulse; loads INIT_PM and enters RUN.
REQ-007 in_valid  in  1  branch metrics and predecessor metrics are valid this cycle.
REQ-008 path_0_bmc  in  2  Hamming branch metric (0..2) for the transition from predecessor 0.
REQ-009 path_1_bmc  in  2  Hamming branch metric (0..2) for the transition from predecessor 1.
REQ-010 pm_in0  in  PM_W  path metric of predecessor state 0.
REQ-011 pm_in1  in  PM_W  path metric of predecessor state 1.
REQ-012 norm_in  in  1  global normalize command, applied to this update.
REQ-013 pm_out  out  PM_W  registered survivor path metric of this state.
REQ-014 decision  out  1  registered survivor select: 0 = predecessor 0, 1 = predecessor 1.
REQ-015 out_valid  out  1  one-cycle pulse; pm_out and decision were updated this cycle.
REQ-016 norm_req  out  1  registered; equals pm_out[PM_W-1].
REQ-017 step_cnt  out  STEP_W  number of accepted updates since the last start.

Function
REQ-018 The FSM SHALL have two states. IDLE: in_valid is ignored. RUN: every in_valid cycle is an accepted update.
REQ-019 start SHALL be accepted in either state. On start: pm_out <= INIT_PM, decision <= 0, step_cnt <= 0, out_valid <= 0, state <= RUN.
REQ-020 start SHALL take priority over a simultaneous in_valid; the update in that cycle is discarded.
REQ-021 cand0 = pm_in0 + path_0_bmc and cand1 = pm_in1 + path_1_bmc SHALL be computed at PM_W+1 bits.
REQ-022 The selected metric SHALL be the smaller candidate. decision = 1 only when cand1 < cand0; a tie selects predecessor 0.
REQ-023 If norm_in = 1, 2^(PM_W-1) SHALL be subtracted from the selected metric, floored at 0.
REQ-024 After any normalization, a result above 2^PM_W-1 SHALL saturate to 2^PM_W-1.
REQ-025 Latency SHALL be exactly one cycle: an accepted update at edge N yields pm_out, decision and out_valid=1 after edge N.
REQ-026 out_valid SHALL be 0 in every cycle with no accepted update; pm_out and decision hold their values.
REQ-027 step_cnt SHALL increment by 1 per accepted update and wrap from 2^STEP_W-1 to 0.
REQ-028 Inputs SHALL be sampled only on accepted cycles; values on unaccepted cycles have no effect.
REQ-029 There SHALL be no back-pressure; one update per cycle is sustained indefinitely.

Reset
REQ-030 When rst_n = 0, asynchronously: pm_out = 0, decision = 0, out_valid = 0, norm_req = 0, step_cnt = 0, state = IDLE.
REQ-031 Reset asserted mid-frame SHALL abandon the frame. After deassertion, the block stays in IDLE until the next start.
REQ-032 Reset deassertion is synchronized externally; the block SHALL NOT add a reset synchronizer.

Verification (PM_W=8, INIT_PM=0)
REQ-033 Reset: assert rst_n=0 mid-run, without a clock edge -> all outputs 0 immediately; in_valid pulses afterward -> out_valid stays 0.
REQ-034 Basic update: start, then pm_in0=10, path_0_bmc=2, pm_in1=9, path_1_bmc=1, in_valid=1 -> next cycle pm_out=10, decision=1, out_valid=1, step_cnt=1.
REQ-035 Tie: pm_in0=5, bm0=1, pm_in1=4, bm1=2 -> pm_out=6, decision=0.
REQ-036 Saturation: pm_in0=254, bm0=2, pm_in1=255, bm1=2 -> pm_out=255, decision=0.
REQ-037 Normalize: pm_in0=200, bm0=0, pm_in1=210, bm1=1 with norm_in=1 -> pm_out=72, norm_req=0; same inputs with norm_in=0 -> pm_out=200, norm_req=1.
REQ-038 Priority and wrap: start together with in_valid -> pm_out=0, out_valid=0, step_cnt=0; then 1024 consecutive updates -> step_cnt=0.
